// File: rtl/clk_div_bank_if.sv
// Divide-ratio write port for clk_div_bank: strobe, channel, ratio and acknowledge.
// The master drives the write; the divider bank returns a one-cycle acknowledge.
interface clk_div_bank_if #(
  parameter int unsigned CHW = 2,
  parameter int unsigned DW  = 16
);
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [DW-1:0]  wr_div;
  logic           wr_ack;

  modport master (
    output wr_en,
    output wr_ch,
    output wr_div,
    input  wr_ack
  );

  modport slave (
    input  wr_en,
    input  wr_ch,
    input  wr_div,
    output wr_ack
  );
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel clock-enable generator: per-channel TICK enable and near-50% square wave,
// runtime ratios applied at period boundaries, global SYNC phase realign.
module clk_div_bank #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DW          = 16,
  parameter int unsigned CHW         = 2,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic [NCH-1:0]     run_i,
  input  logic               sync_i,
  clk_div_bank_if.slave      wr_bus,
  output logic [NCH-1:0]     pend_o,
  output logic [NCH-1:0]     tick_o,
  output logic [NCH-1:0]     sqw_o
);

  localparam logic [DW-1:0] One    = DW'(1);
  localparam logic [DW-1:0] DivRst = DW'(DEFAULT_DIV);

  logic [CHW-1:0] wr_ch;
  logic [DW-1:0]  wr_val;
  logic           ack_d, ack_q;

  assign wr_ch  = wr_bus.wr_ch;
  // A zero ratio has no meaning; treat it as divide-by-one.
  assign wr_val = (wr_bus.wr_div == '0) ? One : wr_bus.wr_div;
  assign ack_d  = wr_bus.wr_en && (32'(wr_ch) < NCH);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign wr_bus.wr_ack = ack_q;

  for (genvar g = 0; g < NCH; g++) begin : gen_ch
    logic [DW-1:0] div_q, div_d;
    logic [DW-1:0] sdiv_q, sdiv_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cnt_nxt, hi;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic          sqw_q, sqw_d;
    logic          hit, last;

    assign hit     = wr_bus.wr_en && (32'(wr_ch) == g);
    assign last    = (cnt_q == div_q - One);
    assign cnt_nxt = last ? '0 : cnt_q + One;
    // High phase is ceil(div/2), so odd ratios spend the extra cycle high.
    assign hi      = div_q - (div_q >> 1);

    always_comb begin
      div_d  = div_q;
      sdiv_d = sdiv_q;
      pend_d = pend_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      sqw_d  = sqw_q;

      if (sync_i) begin
        cnt_d = '0;
        sqw_d = 1'b1;
        if (hit) begin
          div_d  = wr_val;
          pend_d = 1'b0;
        end else if (pend_q) begin
          div_d  = sdiv_q;
          pend_d = 1'b0;
        end
      end else if (run_i[g]) begin
        cnt_d  = cnt_nxt;
        tick_d = last;
        sqw_d  = (cnt_nxt < hi);
        if (last && pend_q) begin
          div_d  = sdiv_q;
          pend_d = 1'b0;
        end
        // A write landing on the wrap edge is held for the following wrap.
        if (hit) begin
          sdiv_d = wr_val;
          pend_d = 1'b1;
        end
      end else if (hit) begin
        div_d  = wr_val;
        cnt_d  = '0;
        pend_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (clr_i) begin
        div_q  <= DivRst;
        sdiv_q <= DivRst;
        pend_q <= 1'b0;
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sqw_q  <= 1'b0;
      end else begin
        div_q  <= div_d;
        sdiv_q <= sdiv_d;
        pend_q <= pend_d;
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
        sqw_q  <= sqw_d;
      end
    end

    assign pend_o[g] = pend_q;
    assign tick_o[g] = tick_q;
    assign sqw_o[g]  = sqw_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: expected TICK/SQW/PEND patterns are hand-computed per edge.
module tb_clk_div_bank;
  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned CHW = 3;

  logic           clk = 1'b0;
  logic           clr;
  logic [NCH-1:0] run;
  logic           sync;
  logic [NCH-1:0] pend, tick, sqw;
  int             checks = 0;
  int             errors = 0;

  clk_div_bank_if #(.CHW(CHW), .DW(DW)) bus ();

  clk_div_bank #(.NCH(NCH), .DW(DW), .CHW(CHW), .DEFAULT_DIV(2)) dut (
    .clk_i  (clk),
    .clr_i  (clr),
    .run_i  (run),
    .sync_i (sync),
    .wr_bus (bus.slave),
    .pend_o (pend),
    .tick_o (tick),
    .sqw_o  (sqw)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; run = '0; sync = 1'b0; bus.wr_en = 1'b0;
    step();
    step();
    clr = 1'b0;
  endtask

  task automatic wr(input int ch, input int v);
    bus.wr_en = 1'b1; bus.wr_ch = CHW'(ch); bus.wr_div = DW'(v);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; run = '1; sync = 1'b1;
    bus.wr_en = 1'b1; bus.wr_ch = 3'd1; bus.wr_div = 16'd9;
    step();
    step();
    checks += 4;
    if (tick !== 4'b0000) begin errors++; $display("FAIL reset_tick got %b exp 0000", tick); end
    if (sqw !== 4'b0000) begin errors++; $display("FAIL reset_sqw got %b exp 0000", sqw); end
    if (pend !== 4'b0000) begin errors++; $display("FAIL reset_pend got %b exp 0000", pend); end
    if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", bus.wr_ack); end
  endtask

  task automatic test_div2();
    logic [3:0] e;
    clr = 1'b0; sync = 1'b0; bus.wr_en = 1'b0; run = '1;
    for (int k = 1; k <= 4; k++) begin
      step();
      e = (k % 2 == 0) ? 4'hF : 4'h0;
      checks += 3;
      if (tick !== e) begin errors++; $display("FAIL div2_tick edge %0d got %b exp %b", k, tick, e); end
      if (sqw !== e) begin errors++; $display("FAIL div2_sqw edge %0d got %b exp %b", k, sqw, e); end
      if (pend !== 4'b0000) begin errors++; $display("FAIL div2_pend edge %0d got %b exp 0000", k, pend); end
    end
  endtask

  task automatic test_stopped_write();
    logic [11:0] et, es;
    et = 12'b1000_1000_1000;
    es = 12'b1001_1001_1001;
    do_clr();
    wr(1, 4);
    checks += 2;
    if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL stop_ack got %b exp 1", bus.wr_ack); end
    if (pend !== 4'b0000) begin errors++; $display("FAIL stop_pend got %b exp 0000", pend); end
    run = 4'b0010;
    step();
    checks++;
    if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL stop_ack_pulse got %b exp 0", bus.wr_ack); end
    // The edge above is edge 1 of the run; continue from edge 2.
    checks++;
    if ({sqw[1], tick[1]} !== {es[0], et[0]}) begin
      errors++; $display("FAIL stop_edge1 got sqw=%b tick=%b exp sqw=%b tick=%b", sqw[1], tick[1], es[0], et[0]);
    end
    for (int k = 2; k <= 12; k++) begin
      step();
      checks += 3;
      if (tick[1] !== et[k-1]) begin errors++; $display("FAIL stop_tick1 edge %0d got %b exp %b", k, tick[1], et[k-1]); end
      if (sqw[1] !== es[k-1]) begin errors++; $display("FAIL stop_sqw1 edge %0d got %b exp %b", k, sqw[1], es[k-1]); end
      if (tick[0] !== 1'b0) begin errors++; $display("FAIL stop_tick0 edge %0d got %b exp 0", k, tick[0]); end
    end
  endtask

  task automatic test_pend_update();
    logic [10:0] et, es, ep;
    et = 11'b100_1001_0000;
    es = 11'b101_1011_0011;
    ep = 11'b000_0000_1110;
    do_clr();
    wr(0, 5);
    run = 4'b0001;
    for (int k = 1; k <= 11; k++) begin
      if (k == 2) begin
        bus.wr_en = 1'b1; bus.wr_ch = 3'd0; bus.wr_div = 16'd3;
      end
      step();
      bus.wr_en = 1'b0;
      checks += 3;
      if (tick[0] !== et[k-1]) begin errors++; $display("FAIL pend_tick0 edge %0d got %b exp %b", k, tick[0], et[k-1]); end
      if (sqw[0] !== es[k-1]) begin errors++; $display("FAIL pend_sqw0 edge %0d got %b exp %b", k, sqw[0], es[k-1]); end
      if (pend[0] !== ep[k-1]) begin errors++; $display("FAIL pend_pend0 edge %0d got %b exp %b", k, pend[0], ep[k-1]); end
      if (k == 2) begin
        checks++;
        if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL pend_ack got %b exp 1", bus.wr_ack); end
      end
    end
  endtask

  task automatic test_zero_invalid();
    do_clr();
    wr(2, 0);
    checks += 2;
    if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL zero_ack got %b exp 1", bus.wr_ack); end
    if (pend !== 4'b0000) begin errors++; $display("FAIL zero_pend got %b exp 0000", pend); end
    run = 4'b0101;
    for (int k = 1; k <= 4; k++) begin
      if (k == 1) begin
        bus.wr_en = 1'b1; bus.wr_ch = 3'd4; bus.wr_div = 16'd7;
      end
      step();
      bus.wr_en = 1'b0;
      checks += 5;
      if (tick[2] !== 1'b1) begin errors++; $display("FAIL zero_tick2 edge %0d got %b exp 1", k, tick[2]); end
      if (sqw[2] !== 1'b1) begin errors++; $display("FAIL zero_sqw2 edge %0d got %b exp 1", k, sqw[2]); end
      if (tick[0] !== (k % 2 == 0)) begin errors++; $display("FAIL inv_tick0 edge %0d got %b exp %b", k, tick[0], k % 2 == 0); end
      if (pend !== 4'b0000) begin errors++; $display("FAIL inv_pend edge %0d got %b exp 0000", k, pend); end
      if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL inv_ack edge %0d got %b exp 0", k, bus.wr_ack); end
    end
  endtask

  task automatic test_sync();
    logic [3:0] et [7];
    logic [1:0] es [7];
    et = '{4'b0000, 4'b0100, 4'b0011, 4'b0100, 4'b1000, 4'b0111, 4'b0000};
    es = '{2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11};
    do_clr();
    wr(0, 3);
    wr(1, 3);
    wr(2, 6);
    wr(3, 7);
    run = 4'b0001;
    step();
    run = 4'b1111;
    step();
    step();
    wr(2, 2);
    checks++;
    if (pend !== 4'b0100) begin errors++; $display("FAIL sync_prepend got %b exp 0100", pend); end
    sync = 1'b1;
    bus.wr_en = 1'b1; bus.wr_ch = 3'd3; bus.wr_div = 16'd5;
    step();
    sync = 1'b0; bus.wr_en = 1'b0;
    checks += 4;
    if (tick !== 4'b0000) begin errors++; $display("FAIL sync_tick got %b exp 0000", tick); end
    if (sqw !== 4'b1111) begin errors++; $display("FAIL sync_sqw got %b exp 1111", sqw); end
    if (pend !== 4'b0000) begin errors++; $display("FAIL sync_pend got %b exp 0000", pend); end
    if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL sync_ack got %b exp 1", bus.wr_ack); end
    for (int k = 0; k < 7; k++) begin
      step();
      checks += 2;
      if (tick !== et[k]) begin errors++; $display("FAIL sync_tick edge %0d got %b exp %b", k + 1, tick, et[k]); end
      if (sqw[1:0] !== es[k]) begin errors++; $display("FAIL sync_sqw01 edge %0d got %b exp %b", k + 1, sqw[1:0], es[k]); end
    end
  endtask

  task automatic test_clr_mid();
    logic [3:0] e;
    wr(3, 9);
    checks++;
    if (pend !== 4'b1000) begin errors++; $display("FAIL clr_prepend got %b exp 1000", pend); end
    clr = 1'b1;
    bus.wr_en = 1'b1; bus.wr_ch = 3'd0; bus.wr_div = 16'd7;
    step();
    clr = 1'b0; bus.wr_en = 1'b0; run = 4'b1111;
    checks += 4;
    if (tick !== 4'b0000) begin errors++; $display("FAIL clr_tick got %b exp 0000", tick); end
    if (sqw !== 4'b0000) begin errors++; $display("FAIL clr_sqw got %b exp 0000", sqw); end
    if (pend !== 4'b0000) begin errors++; $display("FAIL clr_pend got %b exp 0000", pend); end
    if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL clr_ack got %b exp 0", bus.wr_ack); end
    for (int k = 1; k <= 4; k++) begin
      step();
      e = (k % 2 == 0) ? 4'hF : 4'h0;
      checks += 2;
      if (tick !== e) begin errors++; $display("FAIL clr_tick edge %0d got %b exp %b", k, tick, e); end
      if (sqw !== e) begin errors++; $display("FAIL clr_sqw edge %0d got %b exp %b", k, sqw, e); end
    end
  endtask

  initial begin
    clr = 1'b1; run = '0; sync = 1'b0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0;
    test_reset();
    test_div2();
    test_stopped_write();
    test_pend_update();
    test_zero_invalid();
    test_sync();
    test_clr_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
